// File: rtl/reg_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reg_cmd_seq
//  Description : Command FIFO feeding a small sequencer that performs WRITE,
//                READ, SET (OR mask) and CLR (AND NOT mask) operations on an
//                external 4-entry register file, returning a response for
//                READ/SET/CLR through a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [1:0]  addr,
    output logic        wr,
    output logic        sel,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // FIFO storage and bookkeeping; entry layout is {op, addr, data}
    logic [19:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [19:0]   w_head;

    // Sequencer state; the bus and response outputs are all registered
    state_t        state_q;
    logic [1:0]    op_q;
    logic [15:0]   mask_q;
    logic          sel_q;
    logic          wr_q;
    logic [1:0]    addr_q;
    logic [15:0]  wdata_q;
    logic          rsp_valid_q;
    logic [15:0]   rsp_data_q;

    assign w_full    = (count_q == C_DEPTH);
    assign w_empty   = (count_q == '0);
    // A pop in the same cycle never frees room for a push while full
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (state_q == ST_IDLE) && !w_empty;
    assign w_head    = fifo_mem_q[rd_ptr_q];

    assign cmd_ready = !w_full;
    assign busy      = (state_q != ST_IDLE) || !w_empty;
    assign sel       = sel_q;
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    // Next pointer/occupancy values; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_op, cmd_addr, cmd_data};
        end
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer: pops one command, drives its bus access(es), then responds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            mask_q      <= '0;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_empty) begin
                        op_q    <= w_head[19:18];
                        mask_q  <= w_head[15:0];
                        sel_q   <= 1'b1;
                        addr_q  <= w_head[17:16];
                        // Only a WRITE drives the bus write in its first access
                        wr_q    <= (w_head[19:18] == OP_WRITE);
                        wdata_q <= (w_head[19:18] == OP_WRITE) ? w_head[15:0] : 16'h0000;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_WRITE) begin
                        sel_q   <= 1'b0;
                        wr_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (op_q == OP_READ) begin
                        sel_q       <= 1'b0;
                        addr_q      <= '0;
                        rsp_data_q  <= rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        // wdata holds the modified read-back for the write-back access
                        wr_q    <= 1'b1;
                        wdata_q <= (op_q == OP_SET) ? (rdata | mask_q) : (rdata & ~mask_q);
                        state_q <= ST_WB;
                    end
                end
                ST_WB: begin
                    sel_q       <= 1'b0;
                    wr_q        <= 1'b0;
                    addr_q      <= '0;
                    wdata_q     <= '0;
                    rsp_data_q  <= wdata_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_cmd_seq
//  Description : Self-checking bench for reg_cmd_seq with a behavioural
//                command/register model, directed scenarios and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_cmd_seq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [1:0]  addr;
    logic        wr;
    logic        sel;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;

    reg_cmd_seq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .addr      (addr),
        .wr        (wr),
        .sel       (sel),
        .wdata     (wdata),
        .rdata     (rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External register file seen by the DUT
    logic [15:0] rf [4];
    assign rdata = rf[addr];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  a;
        logic [15:0] d;
    } cmd_t;

    typedef struct packed {
        logic        w;
        logic [1:0]  a;
        logic [15:0] d;
    } acc_t;

    cmd_t        pend_q[$];   // accepted, not yet started
    acc_t        acc_q[$];    // bus accesses still owed by the running command
    logic [15:0] rsp_q[$];    // responses still owed
    logic [15:0] model_rf [4];
    int          inflight = 0; // 0 none, 1 write in progress, 2 awaiting response
    bit          seeded   = 0;

    task automatic start_cmd(input cmd_t c);
        logic [15:0] nv;
        case (c.op)
            2'b00: begin
                acc_q.push_back('{w: 1'b1, a: c.a, d: c.d});
                model_rf[c.a] = c.d;
                inflight = 1;
            end
            2'b01: begin
                acc_q.push_back('{w: 1'b0, a: c.a, d: 16'h0});
                rsp_q.push_back(model_rf[c.a]);
                inflight = 2;
            end
            default: begin
                nv = (c.op == 2'b10) ? (model_rf[c.a] | c.d) : (model_rf[c.a] & ~c.d);
                acc_q.push_back('{w: 1'b0, a: c.a, d: 16'h0});
                acc_q.push_back('{w: 1'b1, a: c.a, d: nv});
                model_rf[c.a] = nv;
                rsp_q.push_back(nv);
                inflight = 2;
            end
        endcase
    endtask

    // Compare process: every falling edge, DUT outputs versus the model
    always @(negedge clk) begin
        acc_t a;
        if (rst) begin
            if (!seeded) begin
                for (int i = 0; i < 4; i++) rf[i] = 16'($urandom);
                seeded = 1;
            end
            check("rst_bus", {13'd0, sel, wr, addr, wdata}, 32'd0);
            check("rst_rsp", {15'd0, rsp_valid, rsp_data}, 32'd0);
            check("rst_busy", busy, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            pend_q.delete();
            acc_q.delete();
            rsp_q.delete();
            inflight = 0;
            for (int i = 0; i < 4; i++) model_rf[i] = rf[i];
        end else begin
            if (sel) begin
                check("sel_while_rsp", rsp_valid, 0);
                if (acc_q.size() == 0) begin
                    check("start_while_busy", inflight, 0);
                    check("cmd_available", pend_q.size() != 0, 1);
                    if (pend_q.size() != 0) start_cmd(pend_q.pop_front());
                end
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    check("bus_wr", wr, a.w);
                    check("bus_addr", addr, a.a);
                    if (a.w) check("bus_wdata", wdata, a.d);
                end
                if (wr) rf[addr] = wdata;
            end else begin
                check("idle_bus", {13'd0, wr, addr, wdata}, 32'd0);
            end
            check("cmd_ready", cmd_ready, pend_q.size() < DEPTH);
            check("busy", busy, (pend_q.size() != 0) || (inflight != 0));
            if (rsp_valid) begin
                check("rsp_expected", (rsp_q.size() != 0) && (acc_q.size() == 0), 1);
                if (rsp_q.size() != 0) begin
                    check("rsp_data", rsp_data, rsp_q[0]);
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        inflight = 0;
                    end
                end
            end
            if (inflight == 1 && acc_q.size() == 0) inflight = 0;
            if (cmd_valid && cmd_ready) pend_q.push_back('{op: cmd_op, a: cmd_addr, d: cmd_data});
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic push_cmd(input logic [1:0] op, input logic [1:0] a, input logic [15:0] d);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        cmd_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        check("rsp_arrives", rsp_valid, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!busy && !rsp_valid) break;
            @(posedge clk);
            #1;
        end
        check("idle_reached", {busy, rsp_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r3;
        logic [15:0] r2_before;
        int          pulses;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 2'b00;
        cmd_data  = 16'h0000;
        rsp_ready = 1'b1;

        // Asynchronous reset acts before any clock edge
        #1;
        check("por_sel", sel, 0);
        check("por_rsp_valid", rsp_valid, 0);
        check("por_busy", busy, 0);
        check("por_cmd_ready", cmd_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // WRITE then READ, including minimum latency and single-cycle strobe
        push_cmd(2'b00, 2'd2, 16'hA5A5);
        check("lat_first_cycle_sel", sel, 0);
        @(posedge clk); #1;
        check("lat_exec_sel", {sel, wr, addr}, {28'd0, 1'b1, 1'b1, 2'd2});
        check("lat_exec_wdata", wdata, 16'hA5A5);
        @(posedge clk); #1;
        check("write_pulse_width", {sel, wr}, 0);
        push_cmd(2'b01, 2'd2, 16'h0000);
        wait_rsp();
        check("read_back_a5a5", rsp_data, 16'hA5A5);
        wait_idle();

        // SET / CLR read-modify-write on register 1
        push_cmd(2'b00, 2'd1, 16'h00F0);
        push_cmd(2'b10, 2'd1, 16'h0F01);
        wait_rsp();
        check("set_rsp", rsp_data, 16'h0FF1);
        wait_idle();
        check("set_rf", rf[1], 16'h0FF1);
        push_cmd(2'b11, 2'd1, 16'h00F0);
        wait_rsp();
        check("clr_rsp", rsp_data, 16'h0F01);
        wait_idle();
        check("clr_rf", rf[1], 16'h0F01);

        // Held response while the FIFO fills; fifth push waits for a pop
        rsp_ready = 1'b0;
        r3 = rf[3];
        push_cmd(2'b01, 2'd3, 16'h0000);
        wait_rsp();
        push_cmd(2'b00, 2'd0, 16'h1111);
        push_cmd(2'b00, 2'd0, 16'h2222);
        push_cmd(2'b00, 2'd1, 16'h3333);
        push_cmd(2'b00, 2'd0, 16'h4444);
        check("full_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check("rsp_held_valid", rsp_valid, 1);
        check("rsp_held_data", rsp_data, r3);
        check("no_start_while_held", sel, 0);
        rsp_ready = 1'b1;
        push_cmd(2'b00, 2'd1, 16'h5555);
        wait_idle();
        check("order_rf0", rf[0], 16'h4444);
        check("order_rf1", rf[1], 16'h5555);

        // Reset during the write-back of a SET with two commands queued
        r2_before = rf[2];
        push_cmd(2'b10, 2'd2, 16'h00FF);
        push_cmd(2'b01, 2'd0, 16'h0000);
        push_cmd(2'b01, 2'd1, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            if (sel && wr) break;
            @(posedge clk); #1;
        end
        check("wb_reached", {sel, wr}, 2'b11);
        rst = 1'b1;
        #1;
        check("abort_bus", {13'd0, sel, wr, addr, wdata}, 32'd0);
        check("abort_rsp", {15'd0, rsp_valid, rsp_data}, 32'd0);
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (sel) pulses++;
        end
        check("post_reset_sel_pulses", pulses, 0);
        check("no_partial_write", rf[2], r2_before);

        // Sustained back-to-back pushes with immediate response acceptance
        rsp_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            push_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
        end
        wait_idle();

        // Random traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_addr  = 2'($urandom_range(0, 3));
            cmd_data  = 16'($urandom);
            rsp_ready = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        check("drain_pending", pend_q.size(), 0);
        check("drain_accesses", acc_q.size(), 0);
        check("drain_responses", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
